demux_scan_ctrl: RTL and testbench
==================================

# demux_scan_ctrl

Sequencer directly upstream of the 1-to-8 demultiplexer. It drives the demux select and data inputs, stepping through a latched 8-bit channel mask from lowest to highest set bit. Each selected channel is held for a programmable dwell time. A one-cycle done pulse follows the last channel.

## Interface
- `N_CH`, 8, number of demux outputs.
- `SEL_W`, 3, select width, equal to log2(N_CH).
- `DWELL_W`, 4, width of the dwell field.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse; sampled only in IDLE.
- `abort` in 1: terminates the scan; return to IDLE with no done pulse.
- `mask` in N_CH: channels to visit; latched on accepted start.
- `dwell` in DWELL_W: cycles per channel minus 1; latched on accepted start.
- `cont` in 1: continuous-mode request; latched on accepted start; see Configuration.
- `data_in` in 1: bit to route.
- `sel` out SEL_W: to demux `s`.
- `dout` out 1: to demux `i`.
- `chan_valid` out 1: high while a channel is being driven.
- `step` out 1: pulses on the first cycle of each channel.
- `busy` out 1: high in SCAN.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset enters IDLE.
- IDLE with `start`=1 and `mask`≠0:
  - Latch mask, dwell and cont.
  - Load `sel` with the index of the lowest set bit of mask.
  - Load dwell counter = dwell.
  - Go to SCAN.
- IDLE with `start`=1 and `mask`=0: go to DONE directly. No channel is driven.
- SCAN, counter≠0: decrement the counter and hold `sel`.
- SCAN, counter=0 and a higher set bit exists in the latched mask: load `sel` with that index and reload counter = dwell.
- SCAN, counter=0 and no higher set bit exists: go to DONE. Continuous mode overrides this (see Configuration).
- DONE: assert `done` for one cycle, then go to IDLE.
- `abort`=1 in SCAN or DONE: next state is IDLE and `done` stays 0. In IDLE, `abort` has priority over `start`.
- `start` is ignored in SCAN and DONE. No queuing.
- Outputs:
  - `dout` = `data_in` & `chan_valid`. This is combinational, zero latency, and is the only combinational output.
  - All other outputs are registered.
- `sel` holds its last value in IDLE and DONE. It has no effect downstream because `dout`=0 there.
- Counter arithmetic is unsigned DWELL_W bits. dwell=0 means 1 cycle per channel; dwell=15 means 16 cycles per channel.

## Timing
- Reset values: `sel`=0, `chan_valid`=0, `step`=0, `busy`=0, `done`=0, `dout`=0. Latched mask, dwell, cont and the counter reset to 0.
- `start` accepted at edge T:
  - From T+1: SCAN, `busy`=1, `chan_valid`=1, `step`=1.
  - Each channel occupies dwell+1 cycles.
- Scan length is popcount(mask)×(dwell+1) cycles, followed by exactly 1 DONE cycle. IDLE resumes the cycle after DONE.
- Earliest restart: `start` asserted in the first IDLE cycle after DONE.
- Zero mask: `done`=1 at T+1, IDLE at T+2, `busy` never asserted.
- Reset mid-scan: all outputs return to reset values immediately (asynchronous) and hold until release. There is no done pulse.

## Configuration
- `DEMUX_SCAN_REPEAT_EN` defined:
  - When latched cont=1, reaching counter=0 on the highest set bit wraps `sel` to the lowest set bit, reloads the counter and pulses `step`.
  - The FSM stays in SCAN until `abort` or reset, and `done` never fires.
  - cont=0 behaves as in Operation.
- `DEMUX_SCAN_REPEAT_EN` undefined:
  - `cont` is accepted but ignored and the cont latch is not built.
  - Every scan terminates through DONE.

## Test plan
- Reset release, then idle 5 cycles → all outputs 0, `busy`=0.
- mask=8'b1010_0100, dwell=1, data_in=1, start at T:
  - `sel`=2 at T+1..T+2, 5 at T+3..T+4, 7 at T+5..T+6.
  - `step` pulses at T+1, T+3, T+5.
  - `done`=1 at T+7, `busy`=0 at T+7.
- mask=8'hFF, dwell=0, data_in toggling each cycle → `sel` counts 0..7 over 8 cycles; `dout` mirrors `data_in` each cycle; `done` at T+9.
- mask=0, start → `done`=1 at T+1 only; `chan_valid` stays 0.
- mask=8'h81, dwell=3:
  - Assert `abort` at T+3 → IDLE at T+4, no `done`.
  - `start` during SCAN is ignored. Separate scan: `rst_n`=0 mid-scan → outputs 0 within the same cycle.
- With `DEMUX_SCAN_REPEAT_EN`: mask=8'h12, dwell=0, cont=1 → `sel` sequence 1,4,1,4,… for 20 cycles, no `done`; `abort` → IDLE next cycle.

Source files
------------

// File: rtl/demux_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// demux_scan_ctrl_if
// Bundles the request side and the demux-facing side of the scan sequencer.
//
// Signals
//   start      request pulse (master -> slave)
//   abort      terminate scan, return to idle without done (master -> slave)
//   mask       channels to visit, latched on accepted start (master -> slave)
//   dwell      cycles per channel minus 1, latched on accepted start
//   cont       continuous-mode request, latched on accepted start
//   data_in    bit to route through the demux
//   sel        demux select (slave -> master / demux)
//   dout       demux data input, data_in gated by chan_valid
//   chan_valid high while a channel is being driven
//   step       pulses on the first cycle of each channel
//   busy       high while scanning
//   done       one-cycle completion pulse
//
// Modports
//   master : the requester, drives controls and observes status
//   slave  : demux_scan_ctrl
// -----------------------------------------------------------------------------
interface demux_scan_ctrl_if #(
  parameter int N_CH    = 8,
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
);
  logic               start;
  logic               abort;
  logic [N_CH-1:0]    mask;
  logic [DWELL_W-1:0] dwell;
  logic               cont;
  logic               data_in;
  logic [SEL_W-1:0]   sel;
  logic               dout;
  logic               chan_valid;
  logic               step;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, mask, dwell, cont, data_in,
    input  sel, dout, chan_valid, step, busy, done
  );

  modport slave (
    input  start, abort, mask, dwell, cont, data_in,
    output sel, dout, chan_valid, step, busy, done
  );
endinterface

// File: rtl/demux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// demux_scan_ctrl
// Sequencer feeding a 1-to-N_CH demultiplexer. On start it latches a channel
// mask and dwell time, then walks the set bits of the mask from lowest to
// highest, holding each channel for dwell+1 cycles, and finishes with a
// one-cycle done pulse. abort returns to IDLE without done.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    demux_scan_ctrl_if.slave (start/abort/mask/dwell/cont/data_in in,
//          sel/dout/chan_valid/step/busy/done out)
//
// Optional feature
//   DEMUX_SCAN_REPEAT_EN : when defined, a scan started with cont=1 wraps from
//   the highest set channel back to the lowest and never reaches DONE.
//   When undefined, cont is ignored and no cont latch exists.
//
// dout is the only combinational output (data_in & chan_valid); everything
// else is registered.
// -----------------------------------------------------------------------------
module demux_scan_ctrl #(
  parameter int N_CH    = 8,
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  demux_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  logic [N_CH-1:0]    mask_reg;
  logic [DWELL_W-1:0] dwell_reg;
  logic [DWELL_W-1:0] cnt_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic               chan_valid_reg;
  logic               step_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [SEL_W-1:0]   start_sel;   // lowest set bit of incoming mask
  logic [SEL_W-1:0]   first_sel;   // lowest set bit of latched mask
  logic [SEL_W-1:0]   next_sel;    // lowest latched bit above current sel
  logic               next_found;
  logic               wrap;        // continuous mode active for this scan

  // Descending loops so the last hit (the lowest qualifying index) wins.
  always_comb begin
    start_sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus.mask[i]) start_sel = SEL_W'(i);
    end
  end

  always_comb begin
    first_sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_reg[i]) first_sel = SEL_W'(i);
    end
  end

  always_comb begin
    next_sel   = '0;
    next_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_reg[i] && (SEL_W'(i) > sel_reg)) begin
        next_sel   = SEL_W'(i);
        next_found = 1'b1;
      end
    end
  end

`ifdef DEMUX_SCAN_REPEAT_EN
  logic cont_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_reg <= 1'b0;
    end else if (state_reg == IDLE && !bus.abort && bus.start && (bus.mask != '0)) begin
      cont_reg <= bus.cont;
    end
  end

  assign wrap = cont_reg;
`else
  logic unused_cont;
  assign unused_cont = bus.cont;
  assign wrap        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      mask_reg       <= '0;
      dwell_reg      <= '0;
      cnt_reg        <= '0;
      sel_reg        <= '0;
      chan_valid_reg <= 1'b0;
      step_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          step_reg <= 1'b0;
          done_reg <= 1'b0;
          if (bus.abort) begin
            state_reg <= IDLE;
          end else if (bus.start) begin
            if (bus.mask != '0) begin
              mask_reg       <= bus.mask;
              dwell_reg      <= bus.dwell;
              cnt_reg        <= bus.dwell;
              sel_reg        <= start_sel;
              state_reg      <= SCAN;
              busy_reg       <= 1'b1;
              chan_valid_reg <= 1'b1;
              step_reg       <= 1'b1;
            end else begin
              // Empty mask: nothing to drive, report completion at once.
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end

        SCAN: begin
          if (bus.abort) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            chan_valid_reg <= 1'b0;
            step_reg       <= 1'b0;
            done_reg       <= 1'b0;
          end else if (cnt_reg != '0) begin
            cnt_reg  <= cnt_reg - 1'b1;
            step_reg <= 1'b0;
          end else if (next_found) begin
            sel_reg  <= next_sel;
            cnt_reg  <= dwell_reg;
            step_reg <= 1'b1;
          end else if (wrap) begin
            sel_reg  <= first_sel;
            cnt_reg  <= dwell_reg;
            step_reg <= 1'b1;
          end else begin
            state_reg      <= DONE;
            busy_reg       <= 1'b0;
            chan_valid_reg <= 1'b0;
            step_reg       <= 1'b0;
            done_reg       <= 1'b1;
          end
        end

        DONE: begin
          // Abort here lands in IDLE too; either way done lasts one cycle.
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end

        default: begin
          state_reg      <= IDLE;
          busy_reg       <= 1'b0;
          chan_valid_reg <= 1'b0;
          step_reg       <= 1'b0;
          done_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel        = sel_reg;
  assign bus.chan_valid = chan_valid_reg;
  assign bus.step       = step_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.dout       = bus.data_in & chan_valid_reg;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demux_scan_ctrl
// Directed self-checking bench for demux_scan_ctrl. Inputs are driven on the
// falling edge and outputs sampled 1 time unit later, so "cycle T+k" is the
// k-th falling edge after the cycle in which start was high.
// Observation vector: {sel[2:0], chan_valid, step, busy, done, dout}.
// -----------------------------------------------------------------------------
module tb_demux_scan_ctrl;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   fails;

  demux_scan_ctrl_if #(.N_CH(8), .SEL_W(3), .DWELL_W(4)) bus ();

  demux_scan_ctrl #(.N_CH(8), .SEL_W(3), .DWELL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {bus.sel, bus.chan_valid, bus.step, bus.busy, bus.done, bus.dout};
  endfunction

  task automatic idle_inputs();
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.mask    = '0;
    bus.dwell   = '0;
    bus.cont    = 1'b0;
    bus.data_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk); #1;
    o = obs();
    tests_run++;
    if (o !== 8'h00) begin
      fails++;
      $display("FAIL reset_asserted: got %b want %b", o, 8'h00);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      o = obs();
      tests_run++;
      if (o !== 8'h00) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got %b want %b", k, o, 8'h00);
      end
    end
    $display("[TB] test_reset complete");
  endtask

  task automatic test_scan_basic();
    logic [7:0] exp_tab [8];
    logic [7:0] o;
    exp_tab = '{8'b010_11101, 8'b010_10101, 8'b101_11101, 8'b101_10101,
                8'b111_11101, 8'b111_10101, 8'b111_00010, 8'b111_00000};
    @(negedge clk);
    bus.mask = 8'b1010_0100; bus.dwell = 4'd1; bus.data_in = 1'b1; bus.start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      o = obs();
      tests_run++;
      if (o !== exp_tab[k-1]) begin
        fails++;
        $display("FAIL scan_basic T+%0d: got %b want %b", k, o, exp_tab[k-1]);
      end
    end
    $display("[TB] test_scan_basic complete");
  endtask

  task automatic test_full_mask();
    logic [7:0] o;
    logic [7:0] e;
    logic [2:0] s;
    @(negedge clk);
    bus.mask = 8'hFF; bus.dwell = 4'd0; bus.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k <= 8) begin
        bus.data_in = k[0];
        s = 3'(k - 1);
        e = {s, 1'b1, 1'b1, 1'b1, 1'b0, bus.data_in};
      end else begin
        bus.data_in = 1'b1;
        e = {3'd7, 1'b0, 1'b0, 1'b0, (k == 9), 1'b0};
      end
      #1;
      o = obs();
      tests_run++;
      if (o !== e) begin
        fails++;
        $display("FAIL full_mask T+%0d: got %b want %b", k, o, e);
      end
    end
    $display("[TB] test_full_mask complete");
  endtask

  task automatic test_zero_mask();
    logic [3:0] o;
    logic [3:0] e;
    @(negedge clk);
    bus.mask = 8'h00; bus.dwell = 4'd5; bus.data_in = 1'b1; bus.start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      o = {bus.chan_valid, bus.step, bus.busy, bus.done};
      e = (k == 1) ? 4'b0001 : 4'b0000;
      tests_run++;
      if (o !== e) begin
        fails++;
        $display("FAIL zero_mask T+%0d: got %b want %b (cv,step,busy,done)", k, o, e);
      end
    end
    $display("[TB] test_zero_mask complete");
  endtask

  task automatic test_abort();
    logic [7:0] exp_tab [5];
    logic [7:0] o;
    exp_tab = '{8'b000_11101, 8'b000_10101, 8'b000_10101, 8'b000_00000, 8'b000_00000};
    @(negedge clk);
    bus.mask = 8'h81; bus.dwell = 4'd3; bus.data_in = 1'b1; bus.start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (k == 2) begin
        // Restart attempt while scanning must be ignored.
        bus.start = 1'b1;
        bus.mask  = 8'h02;
      end
      if (k == 3) bus.abort = 1'b1;
      #1;
      o = obs();
      tests_run++;
      if (o !== exp_tab[k-1]) begin
        fails++;
        $display("FAIL abort T+%0d: got %b want %b", k, o, exp_tab[k-1]);
      end
    end
    bus.abort = 1'b0;
    $display("[TB] test_abort complete");
  endtask

  task automatic test_reset_mid_scan();
    logic [7:0] o;
    @(negedge clk);
    bus.mask = 8'hFF; bus.dwell = 4'd2; bus.data_in = 1'b1; bus.start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    o = obs();
    tests_run++;
    if (o !== 8'b000_10101) begin
      fails++;
      $display("FAIL rst_mid_pre: got %b want %b", o, 8'b000_10101);
    end
    rst_n = 1'b0;
    #1;
    o = obs();
    tests_run++;
    if (o !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_async: got %b want %b", o, 8'h00);
    end
    @(negedge clk);
    o = obs();
    tests_run++;
    if (o !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_hold: got %b want %b", o, 8'h00);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    o = obs();
    tests_run++;
    if (o !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_release: got %b want %b", o, 8'h00);
    end
    $display("[TB] test_reset_mid_scan complete");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_tab [6];
    logic [7:0] o;
    exp_tab = '{8'b000_11101, 8'b000_00010, 8'b000_00000,
                8'b011_11101, 8'b011_00010, 8'b011_00000};
    @(negedge clk);
    bus.mask = 8'h01; bus.dwell = 4'd0; bus.data_in = 1'b1; bus.start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 3) begin
        // First IDLE cycle after DONE: earliest legal restart.
        bus.start = 1'b1;
        bus.mask  = 8'h08;
      end
      #1;
      o = obs();
      tests_run++;
      if (o !== exp_tab[k-1]) begin
        fails++;
        $display("FAIL back_to_back T+%0d: got %b want %b", k, o, exp_tab[k-1]);
      end
    end
    $display("[TB] test_back_to_back complete");
  endtask

`ifdef DEMUX_SCAN_REPEAT_EN
  task automatic test_cont();
    logic [7:0] o;
    logic [7:0] e;
    logic [2:0] s;
    @(negedge clk);
    bus.mask = 8'h12; bus.dwell = 4'd0; bus.cont = 1'b1; bus.data_in = 1'b1; bus.start = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = (k == 21);
      s = k[0] ? 3'd1 : 3'd4;
      if (k <= 21) e = {s, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      else         e = {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      #1;
      o = obs();
      tests_run++;
      if (o !== e) begin
        fails++;
        $display("FAIL cont_repeat T+%0d: got %b want %b", k, o, e);
      end
    end
    bus.abort = 1'b0;
    bus.cont  = 1'b0;
    $display("[TB] test_cont complete");
  endtask
`else
  task automatic test_cont();
    logic [7:0] exp_tab [4];
    logic [7:0] o;
    exp_tab = '{8'b001_11101, 8'b100_11101, 8'b100_00010, 8'b100_00000};
    @(negedge clk);
    bus.mask = 8'h12; bus.dwell = 4'd0; bus.cont = 1'b1; bus.data_in = 1'b1; bus.start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      o = obs();
      tests_run++;
      if (o !== exp_tab[k-1]) begin
        fails++;
        $display("FAIL cont_ignored T+%0d: got %b want %b", k, o, exp_tab[k-1]);
      end
    end
    bus.cont = 1'b0;
    $display("[TB] test_cont complete");
  endtask
`endif

  initial begin
    tests_run = 0;
    fails     = 0;
    rst_n     = 1'b0;
    idle_inputs();
    test_reset();
    test_scan_basic();
    test_full_mask();
    test_zero_mask();
    test_abort();
    test_reset_mid_scan();
    test_back_to_back();
    test_cont();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
